// File: rtl/timer_irq_source_if.sv
// timer_irq_source_if -- data-memory bus bundle between the CPU load/store
// path (master) and the memory-mapped interval timer (slave).
//   MemRd     : read strobe from the lw decode
//   MemWr     : write strobe from the sw decode
//   Addr      : word-aligned byte address
//   WriteData : store data
//   ReadData  : load data, combinational from the slave
interface timer_irq_source_if;
  logic        MemRd;
  logic        MemWr;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (output MemRd, MemWr, Addr, WriteData, input  ReadData);
  modport slave  (input  MemRd, MemWr, Addr, WriteData, output ReadData);
endinterface

// File: rtl/timer_irq_source.sv
// timer_irq_source -- memory-mapped interval timer raising a sticky, level
// interrupt on counter overflow, plus a read-only count of timeouts.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : data-memory bus (slave side): MemRd/MemWr/Addr/WriteData/ReadData
//   IRQ   : interrupt request, equals TCON.ST
// Register window at BASE: +0 TH, +4 TL, +8 TCON[2:0] = {ST,IE,EN}, +C TCNT.
module timer_irq_source #(
  parameter logic [31:0] BASE  = 32'h4000_0000,
  parameter int          CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  timer_irq_source_if.slave    bus,
  output logic                 IRQ
);

  localparam logic [1:0] IDX_TH   = 2'd0;
  localparam logic [1:0] IDX_TL   = 2'd1;
  localparam logic [1:0] IDX_TCON = 2'd2;
  localparam logic [1:0] IDX_TCNT = 2'd3;

  logic [31:0]      r_th;
  logic [31:0]      r_tl;
  logic             r_en;
  logic             r_ie;
  logic             r_st;
  logic [CNT_W-1:0] r_tcnt;

  logic       w_sel;
  logic [1:0] w_idx;
  logic       w_wr_th, w_wr_tl, w_wr_tcon, w_wr_tcnt;
  logic       w_timeout;
  logic       w_unused;

  // Word select inside the 16-byte window; byte offset bits are don't-care.
  assign w_sel    = (bus.Addr[31:4] == BASE[31:4]);
  assign w_idx    = bus.Addr[3:2];
  assign w_unused = ^bus.Addr[1:0];

  assign w_wr_th   = bus.MemWr & w_sel & (w_idx == IDX_TH);
  assign w_wr_tl   = bus.MemWr & w_sel & (w_idx == IDX_TL);
  assign w_wr_tcon = bus.MemWr & w_sel & (w_idx == IDX_TCON);
  assign w_wr_tcnt = bus.MemWr & w_sel & (w_idx == IDX_TCNT);

  // Overflow is judged on the current (pre-edge) EN and TL.
  assign w_timeout = r_en & (r_tl == 32'hFFFF_FFFF);

  // TH: plain software register. A write in a timeout cycle lands after the
  // reload below has already sampled the old value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       r_th <= '0;
    else if (w_wr_th) r_th <= bus.WriteData;
  end

  // TL: software write beats both reload and increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         r_tl <= '0;
    else if (w_wr_tl)   r_tl <= bus.WriteData;
    else if (w_timeout) r_tl <= r_th;
    else if (r_en)      r_tl <= r_tl + 32'd1;
  end

  // TCON: a write replaces all three bits, but a simultaneous enabled timeout
  // is OR-ed into ST so that a clear racing an overflow never loses it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en <= 1'b0;
      r_ie <= 1'b0;
      r_st <= 1'b0;
    end else if (w_wr_tcon) begin
      r_en <= bus.WriteData[0];
      r_ie <= bus.WriteData[1];
      r_st <= bus.WriteData[2] | (w_timeout & r_ie);
    end else if (w_timeout && r_ie) begin
      r_st <= 1'b1;
    end
  end

  // TCNT: free-wrapping timeout count; any write clears it and wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         r_tcnt <= '0;
    else if (w_wr_tcnt) r_tcnt <= '0;
    else if (w_timeout) r_tcnt <= r_tcnt + 1'b1;
  end

  assign IRQ = r_st;

  always_comb begin
    bus.ReadData = 32'h0;
    if (bus.MemRd && w_sel) begin
      unique case (w_idx)
        IDX_TH:   bus.ReadData = r_th;
        IDX_TL:   bus.ReadData = r_tl;
        IDX_TCON: bus.ReadData = {29'h0, r_st, r_ie, r_en};
        IDX_TCNT: bus.ReadData = 32'(r_tcnt);
        default:  bus.ReadData = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_irq_source.sv
module tb_timer_irq_source;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] A_TH   = BASE + 32'h0;
  localparam logic [31:0] A_TL   = BASE + 32'h4;
  localparam logic [31:0] A_TCON = BASE + 32'h8;
  localparam logic [31:0] A_TCNT = BASE + 32'hC;

  logic clk;
  logic reset;
  logic irq;
  int   n_cmp;
  int   n_err;

  timer_irq_source_if bus();

  timer_irq_source #(.BASE(BASE), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .IRQ   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; each write consumes one edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.MemWr     = 1'b1;
    bus.Addr      = a;
    bus.WriteData = d;
    @(posedge clk); #1;
    bus.MemWr     = 1'b0;
  endtask

  // Zero-latency read, no edge consumed.
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.MemRd = 1'b1;
    bus.Addr  = a;
    #1;
    chk(tag, bus.ReadData, exp);
    bus.MemRd = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus.MemRd = 1'b0; bus.MemWr = 1'b0; bus.Addr = '0; bus.WriteData = '0;
    reset = 1'b0;
    #12 reset = 1'b1;
    step(1);

    // Reset state
    chk("rst_irq", 32'(irq), 32'h0);
    rd("rst_th",   A_TH,   32'h0);
    rd("rst_tl",   A_TL,   32'h0);
    rd("rst_tcon", A_TCON, 32'h0);
    rd("rst_tcnt", A_TCNT, 32'h0);

    // Basic timeout: IRQ exactly 4 edges after the TCON write
    wr(A_TH,   32'hFFFF_FFFC);
    wr(A_TL,   32'hFFFF_FFFC);
    wr(A_TCON, 32'h3);
    chk("bt_irq_e0", 32'(irq), 32'h0);
    step(3);
    chk("bt_irq_e3", 32'(irq), 32'h0);
    rd("bt_tl_e3", A_TL, 32'hFFFF_FFFF);
    step(1);
    chk("bt_irq_e4", 32'(irq), 32'h1);
    rd("bt_tl",   A_TL,   32'hFFFF_FFFC);
    rd("bt_tcnt", A_TCNT, 32'h1);
    wr(A_TCON, 32'h0);
    chk("bt_clr_irq", 32'(irq), 32'h0);

    // Periodic with IE = 0: timeout every 2 cycles
    wr(A_TCNT, 32'h0);
    wr(A_TH,   32'hFFFF_FFFE);
    wr(A_TL,   32'hFFFF_FFFE);
    wr(A_TCON, 32'h1);
    step(10);
    rd("per_tcnt", A_TCNT, 32'h5);
    chk("per_irq", 32'(irq), 32'h0);
    wr(A_TCON, 32'h3);                 // TL FE->FF, no timeout on this edge
    chk("per_ie_irq0", 32'(irq), 32'h0);
    step(1);                           // timeout
    chk("per_ie_irq1", 32'(irq), 32'h1);
    rd("per_tcnt6", A_TCNT, 32'h6);

    // Clear collision: write 3'b011 exactly on a timeout edge keeps ST
    step(1);                           // TL -> FF
    wr(A_TCON, 32'h3);                 // timeout edge
    chk("col_keep", 32'(irq), 32'h1);
    rd("col_tcnt", A_TCNT, 32'h7);
    wr(A_TCON, 32'h3);                 // non-timeout edge: clears ST
    chk("col_clr", 32'(irq), 32'h0);

    // Write priority: TL write on a timeout edge
    wr(A_TL, 32'h0000_0010);
    rd("wp_tl",   A_TL,   32'h0000_0010);
    rd("wp_tcnt", A_TCNT, 32'h8);
    chk("wp_irq", 32'(irq), 32'h1);

    // TH write on a timeout edge: reload takes the old TH
    wr(A_TCON, 32'h0);
    wr(A_TH,   32'h5);
    wr(A_TL,   32'hFFFF_FFFF);
    wr(A_TCON, 32'h1);
    wr(A_TH,   32'h9);                 // timeout edge
    rd("thc_tl", A_TL, 32'h5);
    rd("thc_th", A_TH, 32'h9);
    wr(A_TCON, 32'h0);                 // TL 5 -> 6

    // Decode
    wr(BASE + 32'h10, 32'h1234_5678);
    rd("dec_th",   A_TH,   32'h9);
    rd("dec_tl",   A_TL,   32'h6);
    rd("dec_tcon", A_TCON, 32'h0);
    rd("dec_tcnt", A_TCNT, 32'h9);
    rd("dec_out",  BASE + 32'h10, 32'h0);
    bus.Addr = A_TH; #1;
    chk("dec_nord", bus.ReadData, 32'h0);
    wr(A_TCON, 32'hFFFF_FFFF);         // upper bits ignored, ST set by hook
    rd("dec_tcon7", A_TCON, 32'h7);
    chk("dec_irq", 32'(irq), 32'h1);
    wr(A_TCON, 32'h0);

    // TCNT wrap with timeout every cycle, then clear-vs-timeout
    wr(A_TCNT, 32'h0);
    wr(A_TH,   32'hFFFF_FFFF);
    wr(A_TL,   32'hFFFF_FFFF);
    wr(A_TCON, 32'h1);
    step(255);
    rd("wrap_255", A_TCNT, 32'hFF);
    step(1);
    rd("wrap_256", A_TCNT, 32'h0);
    rd("wrap_tl",  A_TL,   32'hFFFF_FFFF);
    chk("wrap_irq", 32'(irq), 32'h0);
    wr(A_TCNT, 32'h0);                 // timeout edge: clear wins
    rd("wrap_clr", A_TCNT, 32'h0);

    // Asynchronous reset mid-count with ST = 1
    wr(A_TCON, 32'h7);
    chk("ar_pre_irq", 32'(irq), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("ar_irq", 32'(irq), 32'h0);
    step(2);
    reset = 1'b1;
    step(3);
    chk("ar_irq_hold", 32'(irq), 32'h0);
    rd("ar_th",   A_TH,   32'h0);
    rd("ar_tl",   A_TL,   32'h0);
    rd("ar_tcon", A_TCON, 32'h0);
    rd("ar_tcnt", A_TCNT, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/timer_irq_source.md
# timer_irq_source

Memory-mapped interval timer that produces the IRQ request consumed by the CPU control unit. It sits on the data-memory bus beside the data RAM and is written and read by sw/lw through MemWr, MemRd, Addr, WriteData and ReadData. When its counter overflows it raises a level interrupt that software clears explicitly. It also keeps a read-only count of timeouts for diagnostics.

## Interface
- BASE, 32'h4000_0000: base byte address of the register window.
- CNT_W, 8: width of the timeout counter TCNT.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- MemRd  input  1  bus read strobe, from the lw decode.
- MemWr  input  1  bus write strobe, from the sw decode.
- Addr  input  32  byte address, word aligned. Addr[1:0] is ignored.
- WriteData  input  32  store data.
- ReadData  output  32  load data, combinational.
- IRQ  output  1  interrupt request to the control unit. Level-sensitive, equal to TCON[2].

## Operation
- Register map, relative to BASE:
  - +0x0 TH: 32-bit reload value, read/write.
  - +0x4 TL: 32-bit counter, read/write.
  - +0x8 TCON: bits [2:0], read/write. Bits [31:3] read as 0 and ignore writes.
  - +0xC TCNT: CNT_W-bit timeout count, read-only. Zero-extended on read. Any write to it clears it to 0.
- TCON bits:
  - TCON[0] EN: counter runs.
  - TCON[1] IE: interrupt enable.
  - TCON[2] ST: interrupt status; IRQ = ST.
- A register is selected when Addr[31:4] == BASE[31:4]. Outside the window the block ignores writes and drives ReadData = 0.
- Read: ReadData = selected register when MemRd = 1 and the address is in the window; otherwise 0.
- Counting, while EN = 1, each cycle:
  - If TL != 32'hFFFF_FFFF, TL <= TL + 1.
  - If TL == 32'hFFFF_FFFF (timeout), TL <= TH, TCNT <= TCNT + 1, and if IE = 1 then ST <= 1.
- TCNT wraps modulo 2^CNT_W; there is no saturation.
- While EN = 0, TL and TCNT hold.
- ST is sticky. It is cleared only by a software write to TCON with WriteData[2] = 0, or by reset.
- Software may set ST by writing 1 (test hook).
- Clearing IE does not clear ST.

## Timing
- Reset (reset = 0, asynchronous) sets TH = 0, TL = 0, TCON = 0, TCNT = 0. Therefore IRQ = 0 and ReadData = 0 while MemRd = 0.
- Writes take effect at the rising edge where MemWr = 1. The new value is readable in the following cycle.
- Reads have zero latency: ReadData is combinational from the current register state.
- Timeout latency: with EN = 1 and TL = 32'hFFFF_FFFF at edge k, TL = TH, ST = 1 and IRQ = 1 after edge k.
- Simultaneous events, resolved per register:
  - Write to TL in a counting or timeout cycle: the write wins; no increment or reload that cycle. TCNT and ST still update if it was a timeout cycle.
  - Write to TH in a timeout cycle: TL reloads from the old TH; the new TH applies at the next timeout.
  - Write to TCON in a timeout cycle with IE (old value) = 1: EN and IE take the written value, and ST <= WriteData[2] | 1. The timeout is not lost.
  - Write to TCNT in a timeout cycle: TCNT <= 0; the clear wins.
- Reset asserted mid-count clears all state immediately, with no edge required. Counting resumes only after software sets EN.
- TH = 32'hFFFF_FFFF with EN = 1 gives a timeout every cycle.

## Test plan
- Reset: assert reset = 0 mid-count with ST = 1 -> IRQ falls to 0 without a clock edge; all four registers read 0 after release.
- Basic timeout:
  - Stimulus: TH = 32'hFFFF_FFFC, TL = 32'hFFFF_FFFC, TCON = 3'b011.
  - Response: IRQ rises exactly 4 edges after the TCON write; TL reads 32'hFFFF_FFFC; TCNT reads 1.
- Periodic with IE = 0:
  - Stimulus: TH = 32'hFFFF_FFFE, TL = 32'hFFFF_FFFE, TCON = 3'b001; run 10 cycles.
  - Response: TCNT = 5; IRQ stays 0.
  - Then write TCON = 3'b011: IRQ rises at the next timeout.
- Clear collision:
  - Stimulus: IE = 1 and ST = 1; write TCON = 3'b011 in the same cycle a timeout occurs.
  - Response: ST stays 1. A write of 3'b011 on a non-timeout cycle drops IRQ the next cycle.
- Write priority: write TL = 32'h0000_0010 in a timeout cycle -> TL reads 32'h0000_0010 (not TH), and TCNT still increments.
- Decode:
  - Write to BASE + 0x10 -> no register changes.
  - Read with MemRd = 0 -> ReadData = 0.
  - Read TCON with ST = 1, IE = 1, EN = 1 -> 32'h0000_0007.
  - TCNT wrap: 256 timeouts with CNT_W = 8 -> TCNT reads 0.
